standlight_pwm_ctrl: RTL and testbench

STANDLIGHT_PWM_CTRL -- requirements
Module: standlight_pwm_ctrl

---
 rtl/standlight_pkg.sv | 22 ++
 rtl/standlight_btn_sync.sv | 41 ++++
 rtl/standlight_pwm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_standlight_pwm_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/standlight_pkg.sv
// Shared definitions for the stand-light PWM controller.
//
// Contents:
//   BTN_UP / BTN_DN / BTN_OFF  bit positions of the buttons in i_button
//   NUM_BTN                    number of button inputs
//   state_e                    controller state (ST_OFF, ST_ON)
//
// Optional feature macro used by the top level: STANDLIGHT_AUTO_OFF_EN.

package standlight_pkg;

  localparam int unsigned BTN_UP  = 0;
  localparam int unsigned BTN_DN  = 1;
  localparam int unsigned BTN_OFF = 2;
  localparam int unsigned NUM_BTN = 3;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

endpackage

// File: rtl/standlight_btn_sync.sv
// Button conditioning for the stand-light controller.
//
// Each button bit goes through a 2-flop synchroniser followed by a rising-edge
// detector, giving a single-cycle event per press regardless of hold time.
//
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset (clears every flop)
//   i_button   asynchronous active-high buttons (bit0 up, bit1 down, bit2 off)
//   o_event    one-cycle event per rising button edge, valid two edges after
//              the input rises

module standlight_btn_sync
  import standlight_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_BTN-1:0] i_button,
  output logic [NUM_BTN-1:0] o_event
);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= i_button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Because prev_q resets to 0, a button held through reset yields one event.
  assign o_event = sync2_q & ~prev_q;

endmodule

// File: rtl/standlight_pwm_ctrl.sv
// Stand-light controller: button-driven brightness level with PWM lamp drive.
//
// Buttons step the level between 0 (off) and LEVELS-1; the lamp is driven by a
// free-running PWM whose duty is latched at the start of each period so the
// waveform never changes mid-period.
//
// Parameters:
//   LEVELS   number of levels including off (2..16)
//   PWM_W    PWM counter width; period is 2**PWM_W cycles
//   TIMEOUT  idle cycles in ON before auto-off (>= 2)
//
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_button   asynchronous buttons: bit0 up, bit1 down, bit2 off
//   o_level    current level
//   o_pwm      registered lamp drive
//   o_on       high while o_level is non-zero
//
// Build option: define STANDLIGHT_AUTO_OFF_EN to add the idle auto-off timer.

module standlight_pwm_ctrl
  import standlight_pkg::*;
#(
  parameter int unsigned LEVELS  = 5,
  parameter int unsigned PWM_W   = 8,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_BTN-1:0]        i_button,
  output logic [$clog2(LEVELS)-1:0] o_level,
  output logic                      o_pwm,
  output logic                      o_on
);

  localparam int unsigned LW = $clog2(LEVELS);
  localparam int unsigned DW = PWM_W + 1;
  // Numerator width for level * 2**PWM_W, with one spare bit so the unused
  // upper slice of the quotient is never empty.
  localparam int unsigned NW = PWM_W + LW + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(LEVELS - 1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  if (LEVELS < 2 || LEVELS > 16 || TIMEOUT < 2) begin : g_bad_param
    $error("standlight_pwm_ctrl: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Button events
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_ev;
  logic ev_up, ev_dn, ev_off;

  standlight_btn_sync u_btn_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_button (i_button),
    .o_event  (btn_ev)
  );

  assign ev_up  = btn_ev[BTN_UP];
  assign ev_dn  = btn_ev[BTN_DN];
  assign ev_off = btn_ev[BTN_OFF];

  // ---------------------------------------------------------------------------
  // Level FSM (and optional idle timer)
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [LW-1:0]   level_q;

`ifdef STANDLIGHT_AUTO_OFF_EN
  localparam int unsigned IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_q;
  logic          any_ev;
  logic          idle_expired;

  assign any_ev       = |btn_ev;
  assign idle_expired = (idle_q == IDLE_LAST);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_OFF;
      level_q <= '0;
`ifdef STANDLIGHT_AUTO_OFF_EN
      idle_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (ev_up && !ev_dn && !ev_off) begin
            state_q <= ST_ON;
            level_q <= LVL_ONE;
          end
        end
        ST_ON: begin
          if (ev_off) begin
            state_q <= ST_OFF;
            level_q <= '0;
          end else if (ev_up && !ev_dn) begin
            if (level_q != LVL_MAX) begin
              level_q <= level_q + LVL_ONE;
            end
          end else if (ev_dn && !ev_up) begin
            if (level_q == LVL_ONE) begin
              state_q <= ST_OFF;
              level_q <= '0;
            end else begin
              level_q <= level_q - LVL_ONE;
            end
`ifdef STANDLIGHT_AUTO_OFF_EN
          end else if (!any_ev && idle_expired) begin
            // Any event in the expiry cycle wins and restarts the count.
            state_q <= ST_OFF;
            level_q <= '0;
`endif
          end
        end
      endcase
`ifdef STANDLIGHT_AUTO_OFF_EN
      if (any_ev || state_q == ST_OFF || idle_expired) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] cnt_q;
  logic [DW-1:0]    duty_q;
  logic [DW-1:0]    duty_new;
  logic [DW-1:0]    duty_eff;
  logic [NW-1:0]    duty_num;
  logic [NW-1:0]    duty_quot;
  logic [NW-DW-1:0] unused_duty_hi;
  logic             pwm_q;

  // duty = floor(level * 2**PWM_W / (LEVELS-1)); top level yields 2**PWM_W,
  // which needs the extra duty bit to keep the output constantly high.
  assign duty_num       = NW'({level_q, {PWM_W{1'b0}}});
  assign duty_quot      = duty_num / NW'(LEVELS - 1);
  assign duty_new       = duty_quot[DW-1:0];
  assign unused_duty_hi = duty_quot[NW-1:DW];

  // The cycle that starts a period already uses the freshly latched duty.
  assign duty_eff = (cnt_q == '0) ? duty_new : duty_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '0) begin
        duty_q <= duty_new;
      end
      pwm_q <= ({1'b0, cnt_q} < duty_eff);
    end
  end

  assign o_level = level_q;
  assign o_pwm   = pwm_q;
  assign o_on    = (level_q != '0);

endmodule

// File: tb/tb_standlight_pwm_ctrl.sv
// Self-checking bench for standlight_pwm_ctrl.
//
// Stimulus tasks apply button presses and push the expected level changes
// (cycle, level) into a queue; a negedge monitor pops them and checks o_level,
// o_on and o_pwm every cycle against its own level/duty bookkeeping.
// Define STANDLIGHT_AUTO_OFF_EN to build and exercise the auto-off variant.

module tb_standlight_pwm_ctrl;

  localparam int LEVELS = 5;
  localparam int PWM_W  = 8;
  localparam int PERIOD = 1 << PWM_W;
`ifdef STANDLIGHT_AUTO_OFF_EN
  localparam int TIMEOUT = 50;
  localparam bit AUTO    = 1'b1;
`else
  localparam int TIMEOUT = 1_000_000;
  localparam bit AUTO    = 1'b0;
`endif

  localparam logic [2:0] UP  = 3'b001;
  localparam logic [2:0] DN  = 3'b010;
  localparam logic [2:0] OFF = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b000;
  logic [2:0] level;
  logic       pwm;
  logic       on;

  standlight_pwm_ctrl #(
    .LEVELS (LEVELS),
    .PWM_W  (PWM_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_button (btn),
    .o_level  (level),
    .o_pwm    (pwm),
    .o_on     (on)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: level rules and auto-off, expressed per event.
  // ---------------------------------------------------------------------------
  typedef struct {
    int at;
    int lvl;
  } exp_t;

  exp_t q[$];
  int   m_lvl  = 0;
  int   m_last = 0;

  function automatic int duty_of(input int l);
    return (l * PERIOD) / (LEVELS - 1);
  endfunction

  task automatic push_exp(input int at, input int lvl);
    exp_t e;
    e.at  = at;
    e.lvl = lvl;
    q.push_back(e);
  endtask

  // Record any auto-off that lands at or before cycle 'upto'.
  task automatic model_timeout(input int upto);
    if (AUTO && m_lvl != 0 && m_last + TIMEOUT <= upto) begin
      push_exp(m_last + TIMEOUT, 0);
      m_lvl = 0;
    end
  endtask

  task automatic model_event(input logic [2:0] mask, input int ev);
    int nl;
    model_timeout(ev - 1);
    nl = m_lvl;
    if (mask[2])                 nl = 0;
    else if (mask[0] && !mask[1]) nl = (m_lvl + 1 > LEVELS - 1) ? LEVELS - 1 : m_lvl + 1;
    else if (mask[1] && !mask[0]) nl = (m_lvl > 0) ? m_lvl - 1 : 0;
    if (mask != 3'b000) m_last = ev;
    if (nl != m_lvl) push_exp(ev, nl);
    m_lvl = nl;
  endtask

  // Called at a negedge; the level responds on the 3rd rising edge.
  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    int c;
    c = cyc;
    model_event(mask, c + 3);
    model_timeout(c + hold + gap + 2);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    model_timeout(cyc + n + 2);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_at(input logic [2:0] mask, input int target_ev);
    int n;
    n = target_ev - 3 - cyc;
    if (n > 0) idle(n);
    press(mask, 1, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int cur      = 0;
  int exp_duty = 0;
  int hi_cnt   = 0;
  bit in_per   = 1'b0;

  always @(negedge clk) begin
    int   k;
    int   ph;
    int   full;
    exp_t e;
    if (!rst_n) begin
      cur      = 0;
      exp_duty = 0;
      hi_cnt   = 0;
      in_per   = 1'b0;
    end else begin
      k = cyc;
      while (q.size() > 0 && q[0].at <= k) begin
        e   = q.pop_front();
        cur = e.lvl;
      end
      chk("level", int'(level), cur);
      chk("on", int'(on), int'(cur != 0));
      if (k >= 1) begin
        ph = (k - 1) % PERIOD;
        chk("pwm", int'(pwm), int'(ph < exp_duty));
        if (ph == 0) begin
          hi_cnt = 0;
          in_per = 1'b1;
        end
        hi_cnt = hi_cnt + int'(pwm);
        if (ph == PERIOD - 1 && in_per) begin
          full = (exp_duty > PERIOD) ? PERIOD : exp_duty;
          chk("pwm_period_high", hi_cnt, full);
        end
      end
      if (k % PERIOD == 0) exp_duty = duty_of(cur);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] mask;
    int         r;
    int         n;

    repeat (3) @(negedge clk);
    chk("reset_level", int'(level), 0);
    chk("reset_on", int'(on), 0);
    chk("reset_pwm", int'(pwm), 0);
    rst_n = 1'b1;

    // Step up to level 3, then sit for full periods at 192/256.
    repeat (3) press(UP, 2, 6);
    idle(600);

    // Saturate at the top level, then step all the way down.
    repeat (6) press(UP, 1, 4);
    idle(600);
    repeat (5) press(DN, 3, 4);
    idle(600);

    // Same-cycle resolution at level 2.
    repeat (2) press(UP, 1, 3);
    press(UP | DN | OFF, 2, 4);
    repeat (2) press(UP, 1, 3);
    press(UP | DN, 2, 4);
    idle(300);

    // Level 1 -> 3 requested around counter 100 of a period.
    press(OFF, 1, 3);
    press(UP, 1, 3);
    n = (90 - (cyc % PERIOD) + PERIOD) % PERIOD;
    idle(n);
    press(UP, 1, 1);
    press(UP, 1, 1);
    idle(600);

`ifdef STANDLIGHT_AUTO_OFF_EN
    // Event exactly in the expiry cycle restarts the idle count.
    press(OFF, 1, 3);
    repeat (2) press(UP, 1, 3);
    press_at(UP | DN, m_last + TIMEOUT);
    idle(80);
    // One cycle too late: the light times out first.
    repeat (2) press(UP, 1, 3);
    press_at(UP | DN, m_last + TIMEOUT + 1);
    idle(80);
`endif

    // Randomised presses.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: mask = UP;
        4, 5, 6:    mask = DN;
        7:          mask = OFF;
        8:          mask = UP | DN;
        default:    mask = 3'($urandom_range(1, 7));
      endcase
      press(mask, $urandom_range(1, 5), $urandom_range(1, AUTO ? 70 : 30));
    end
    idle(600);

    // Asynchronous reset mid-period with up held through it.
    repeat (4) press(UP, 1, 2);
    idle(300);
    btn = UP;
    @(posedge clk);
    #2;
    chk("pre_reset_pwm", int'(pwm), int'(m_lvl == LEVELS - 1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_level", int'(level), 0);
    chk("async_reset_on", int'(on), 0);
    chk("async_reset_pwm", int'(pwm), 0);
    repeat (2) @(negedge clk);
    q.delete();
    m_lvl  = 0;
    m_last = 0;
    rst_n  = 1'b1;
    model_event(UP, cyc + 3);
    model_timeout(cyc + 12);
    repeat (10) @(negedge clk);
    chk("post_reset_level", int'(level), m_lvl);
    btn = 3'b000;
    idle(300);

    idle(40);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
